// File: rtl/esc_interface_pkg.sv
// Shared types and constants for the ESC PWM stage and the flight controller.
// Pulse widths are counted in clocks; speeds are 11-bit unsigned motor commands.
package esc_interface_pkg;

    localparam int unsigned SPD_W        = 11;
    localparam int unsigned WIDTH_W      = 17;
    localparam int unsigned PERIOD_W_DEF = 20;
    localparam int unsigned MIN_PULSE    = 50000;
    localparam int unsigned SPD_SCALE    = 3;
    localparam int unsigned ARM_PERIODS  = 4;

    localparam logic [SPD_W-1:0] CAL_SPEED     = 11'h1B0;
    localparam logic [SPD_W-1:0] MIN_RUN_SPEED = 11'h0C0;

    typedef logic [SPD_W-1:0] spd_t;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2
    } arm_state_t;

    // Pulse width for a given speed; the operand ranges keep this inside 17 bits.
    function automatic logic [WIDTH_W-1:0] pulse_width(input spd_t spd,
                                                       input int unsigned min_pulse,
                                                       input int unsigned scale);
        return WIDTH_W'(min_pulse) + WIDTH_W'(scale) * WIDTH_W'(spd);
    endfunction

endpackage

// File: rtl/esc_interface_if.sv
// Speed-command / PWM bundle between the flight controller and the ESC stage.
interface esc_interface_if;
    import esc_interface_pkg::*;

    logic wrt;
    logic arm;
    spd_t frnt_spd;
    spd_t bck_spd;
    spd_t lft_spd;
    spd_t rght_spd;
    logic frnt;
    logic bck;
    logic lft;
    logic rght;
    logic armed;

    modport master (
        output wrt, arm, frnt_spd, bck_spd, lft_spd, rght_spd,
        input  frnt, bck, lft, rght, armed
    );

    modport slave (
        input  wrt, arm, frnt_spd, bck_spd, lft_spd, rght_spd,
        output frnt, bck, lft, rght, armed
    );

endinterface

// File: rtl/esc_interface_chan.sv
// One ESC channel: shadow/active speed staging and the registered PWM compare.
// The output is computed one cycle ahead so it is high exactly in cycles 0..W-1.
module esc_interface_chan #(
    parameter int unsigned PERIOD_W    = esc_interface_pkg::PERIOD_W_DEF,
    parameter int unsigned MIN_PULSE   = esc_interface_pkg::MIN_PULSE,
    parameter int unsigned SPD_SCALE   = esc_interface_pkg::SPD_SCALE
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_wrt,
    input  logic [esc_interface_pkg::SPD_W-1:0] i_spd,
    input  logic                                i_last,
    input  logic [PERIOD_W-1:0]                 i_cnt,
    input  logic                                i_en_nxt,
    input  logic                                i_min_nxt,
    output logic                                o_pwm
);
    import esc_interface_pkg::*;

    localparam int unsigned CMP_W = (PERIOD_W + 1 > WIDTH_W) ? PERIOD_W + 1 : WIDTH_W;

    spd_t               r_shadow;
    spd_t               r_active;
    logic               r_en;
    logic               r_min;
    logic               r_pwm;
    logic [WIDTH_W-1:0] w_width;
    logic [CMP_W-1:0]   w_cnt_nxt;
    logic               w_hi;

    assign w_width   = r_min ? WIDTH_W'(MIN_PULSE) : pulse_width(r_active, MIN_PULSE, SPD_SCALE);
    assign w_cnt_nxt = CMP_W'(i_cnt) + CMP_W'(1);
    assign w_hi      = w_cnt_nxt < CMP_W'(w_width);

    // A write in the last cycle bypasses the shadow into the period about to start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_en     <= 1'b0;
            r_min    <= 1'b0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_wrt) begin
                r_shadow <= i_spd;
            end
            if (i_last) begin
                r_active <= i_wrt ? i_spd : r_shadow;
                r_en     <= i_en_nxt;
                r_min    <= i_min_nxt;
                r_pwm    <= i_en_nxt;
            end else begin
                r_pwm    <= r_en & w_hi;
            end
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/esc_interface.sv
// ESC interface top: period counter, arming FSM and four PWM channels.
// All period-boundary decisions happen on the edge that enters counter value 0.
module esc_interface #(
    parameter int unsigned PERIOD_W    = esc_interface_pkg::PERIOD_W_DEF,
    parameter int unsigned MIN_PULSE   = esc_interface_pkg::MIN_PULSE,
    parameter int unsigned SPD_SCALE   = esc_interface_pkg::SPD_SCALE,
    parameter int unsigned ARM_PERIODS = esc_interface_pkg::ARM_PERIODS
) (
    input  logic            clk,
    input  logic            rst,
    esc_interface_if.slave  bus
);
    import esc_interface_pkg::*;

    localparam int unsigned PC_W = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;

    logic [PERIOD_W-1:0] r_cnt;
    arm_state_t          r_state;
    logic [PC_W-1:0]     r_per_cnt;
    logic                r_armed;

    logic                w_last;
    logic                w_done;
    logic                w_en_nxt;
    logic                w_min_nxt;
    spd_t                w_spd [4];
    logic [3:0]          w_pwm;

    assign w_last    = (r_cnt == {PERIOD_W{1'b1}});
    assign w_done    = (r_per_cnt == PC_W'(ARM_PERIODS - 1));
    // Any state with arm=1 at the boundary pulses; only ARMING pulses at the minimum.
    assign w_en_nxt  = bus.arm;
    assign w_min_nxt = !((r_state == ST_ARMED) || ((r_state == ST_ARMING) && w_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_state   <= ST_DISARMED;
            r_per_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
            if (w_last) begin
                case (r_state)
                    ST_DISARMED: begin
                        if (bus.arm) begin
                            r_state   <= ST_ARMING;
                            r_per_cnt <= '0;
                        end
                    end
                    ST_ARMING: begin
                        if (!bus.arm) begin
                            r_state <= ST_DISARMED;
                        end else if (w_done) begin
                            r_state <= ST_ARMED;
                            r_armed <= 1'b1;
                        end else begin
                            r_per_cnt <= r_per_cnt + PC_W'(1);
                        end
                    end
                    ST_ARMED: begin
                        if (!bus.arm) begin
                            r_state <= ST_DISARMED;
                            r_armed <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_DISARMED;
                        r_armed <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_spd[0] = bus.frnt_spd;
    assign w_spd[1] = bus.bck_spd;
    assign w_spd[2] = bus.lft_spd;
    assign w_spd[3] = bus.rght_spd;

    for (genvar g = 0; g < 4; g++) begin : g_chan
        esc_interface_chan #(
            .PERIOD_W  (PERIOD_W),
            .MIN_PULSE (MIN_PULSE),
            .SPD_SCALE (SPD_SCALE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_wrt     (bus.wrt),
            .i_spd     (w_spd[g]),
            .i_last    (w_last),
            .i_cnt     (r_cnt),
            .i_en_nxt  (w_en_nxt),
            .i_min_nxt (w_min_nxt),
            .o_pwm     (w_pwm[g])
        );
    end

    assign bus.frnt  = w_pwm[0];
    assign bus.bck   = w_pwm[1];
    assign bus.lft   = w_pwm[2];
    assign bus.rght  = w_pwm[3];
    assign bus.armed = r_armed;

endmodule

// File: tb/tb_esc_interface.sv
// Directed + randomized bench for esc_interface with a period-level reference model.
// Each period the measured high-time of every channel is compared to the model width.
module tb_esc_interface;
    import esc_interface_pkg::*;

    localparam int P_W  = 12;
    localparam int P    = 1 << P_W;
    localparam int MINP = 100;
    localparam int SCL  = 1;
    localparam int ARMP = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    esc_interface_if bus ();

    esc_interface #(
        .PERIOD_W    (P_W),
        .MIN_PULSE   (MINP),
        .SPD_SCALE   (SCL),
        .ARM_PERIODS (ARMP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests;
    int n_fail;

    // model: position in period, arming progress, speed staging, per-period widths
    int m_cnt;
    bit m_on;
    int m_per;
    int m_shadow [4];
    int m_active [4];
    int m_w      [4];
    bit exp_armed;
    int meas     [4];
    bit low_seen [4];
    bit gap      [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int spd_in(input int i);
        case (i)
            0:       return int'(bus.frnt_spd);
            1:       return int'(bus.bck_spd);
            2:       return int'(bus.lft_spd);
            default: return int'(bus.rght_spd);
        endcase
    endfunction

    function automatic logic pwm_out(input int i);
        case (i)
            0:       return bus.frnt;
            1:       return bus.bck;
            2:       return bus.lft;
            default: return bus.rght;
        endcase
    endfunction

    // Advance model and DUT one clock, then sample and check at period end.
    task automatic cycle();
        if (rst) begin
            m_cnt = 0;
            m_on  = 0;
            m_per = 0;
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
                m_w[i]      = 0;
            end
        end else begin
            if (m_cnt == P - 1) begin
                for (int i = 0; i < 4; i++)
                    m_active[i] = bus.wrt ? spd_in(i) : m_shadow[i];
                if (bus.arm) begin
                    if (!m_on) begin
                        m_on  = 1;
                        m_per = 0;
                    end else begin
                        m_per++;
                    end
                end else begin
                    m_on = 0;
                end
                for (int i = 0; i < 4; i++)
                    m_w[i] = !m_on ? 0 : ((m_per < ARMP) ? MINP : MINP + SCL * m_active[i]);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            if (bus.wrt)
                for (int i = 0; i < 4; i++) m_shadow[i] = spd_in(i);
        end
        exp_armed = m_on && (m_per >= ARMP);
        if (m_cnt == 0)
            for (int i = 0; i < 4; i++) begin
                meas[i] = 0; low_seen[i] = 0; gap[i] = 0;
            end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pwm_out(i) === 1'b1) begin
                meas[i]++;
                if (low_seen[i]) gap[i] = 1;
            end else begin
                low_seen[i] = 1;
            end
        end
        if (m_cnt == 0 || m_cnt == P - 1)
            chk($sformatf("armed_at_cnt%0d", m_cnt), 32'(bus.armed), 32'(exp_armed));
        if (m_cnt == P - 1)
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("width_ch%0d", i), meas[i], m_w[i]);
                chk($sformatf("contig_ch%0d", i), 32'(gap[i]), 0);
            end
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_cnt != target && guard <= P + 2) begin
            cycle();
            guard++;
        end
        chk($sformatf("reach_cnt%0d", target), m_cnt, target);
    endtask

    task automatic end_period();
        cycle();
        run_to(P - 1);
    endtask

    task automatic check_all_low(input string tag);
        chk({tag, "_frnt"}, 32'(bus.frnt), 0);
        chk({tag, "_bck"},  32'(bus.bck),  0);
        chk({tag, "_lft"},  32'(bus.lft),  0);
        chk({tag, "_rght"}, 32'(bus.rght), 0);
        chk({tag, "_armed"}, 32'(bus.armed), 0);
    endtask

    task automatic rand_speeds();
        bus.frnt_spd = spd_t'($urandom_range(0, 2047));
        bus.bck_spd  = spd_t'($urandom_range(0, 2047));
        bus.lft_spd  = spd_t'($urandom_range(0, 2047));
        bus.rght_spd = spd_t'($urandom_range(0, 2047));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_cnt   = 0;
        m_on    = 0;
        m_per   = 0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 0; m_active[i] = 0; m_w[i] = 0;
            meas[i] = 0; low_seen[i] = 0; gap[i] = 0;
        end
        rst = 1'b1;
        bus.wrt = 1'b0;
        bus.arm = 1'b0;
        bus.frnt_spd = '0;
        bus.bck_spd  = '0;
        bus.lft_spd  = '0;
        bus.rght_spd = '0;

        repeat (3) cycle();
        check_all_low("reset");
        rst = 1'b0;

        // disarmed: two silent periods
        run_to(P - 1);
        end_period();

        // calibration speed, arm: ARMP minimum periods then speed-dependent
        bus.frnt_spd = CAL_SPEED;
        bus.bck_spd  = CAL_SPEED;
        bus.lft_spd  = CAL_SPEED;
        bus.rght_spd = CAL_SPEED;
        bus.wrt = 1'b1;
        bus.arm = 1'b1;
        cycle();
        bus.wrt = 1'b0;
        run_to(P - 1);
        repeat (ARMP + 1) end_period();
        chk("armed_after_arming", 32'(bus.armed), 1);

        // mid-period write only affects the next period
        run_to(1000);
        bus.frnt_spd = 11'h200;
        bus.wrt = 1'b1;
        cycle();
        bus.wrt = 1'b0;
        run_to(P - 1);
        end_period();

        // write in the last cycle feeds the very next period
        bus.frnt_spd = 11'h7FF;
        bus.bck_spd  = 11'h000;
        bus.wrt = 1'b1;
        cycle();
        bus.wrt = 1'b0;
        run_to(P - 1);

        // randomized speeds, written mid-period or in the last cycle
        for (int k = 0; k < 2; k++) begin
            run_to(int'($urandom_range(1, P - 2)));
            rand_speeds();
            bus.wrt = 1'b1;
            cycle();
            bus.wrt = 1'b0;
            run_to(P - 1);
            if ($urandom_range(0, 1) == 1) begin
                rand_speeds();
                bus.wrt = 1'b1;
            end
            end_period();
            bus.wrt = 1'b0;
        end

        // reset mid-pulse, then re-arm from scratch with arm held high
        run_to(200);
        rst = 1'b1;
        cycle();
        check_all_low("rst_mid");
        rst = 1'b0;
        run_to(P - 1);
        repeat (ARMP + 1) end_period();
        chk("armed_after_rearm", 32'(bus.armed), 1);

        // arm drop mid-period: pulse completes, next period silent
        run_to(100);
        bus.arm = 1'b0;
        cycle();
        run_to(P - 1);
        end_period();
        chk("armed_after_drop", 32'(bus.armed), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
